// File: rtl/i2c_target_regfile_if.sv
// I2C pad-side bus bundle: synchronous-domain view of SCL/SDA inputs and the open-drain SDA enable.
interface i2c_target_regfile_if;
  logic scl_in;
  logic sda_in;
  logic sda_oe;

  modport master (output scl_in, output sda_in, input sda_oe);
  modport slave  (input scl_in, input sda_in, output sda_oe);
endinterface

// File: rtl/i2c_target_regfile.sv
// I2C target with a NUM_REGS x 8-bit register file, pointer addressing and auto-increment bursts.
// SCL/SDA are oversampled by clk; all bus actions happen on synchronised SCL edges.
module i2c_target_regfile #(
  parameter logic [6:0]   DEV_ADDR = 7'h2A,
  parameter int unsigned  NUM_REGS = 4,
  parameter logic [7:0]   RST_VAL  = 8'h00,
  localparam int unsigned PTR_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  i2c_target_regfile_if.slave   bus,
  output logic [8*NUM_REGS-1:0] regs_q,
  output logic                  wr_stb,
  output logic [PTR_W-1:0]      wr_idx,
  output logic                  busy
);

  localparam int unsigned CNT_W = 4;
  // Bit counter: 0..7 data rises, 8 = byte done / ACK slot pending, 9 = ACK slot clocked.
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(7);
  localparam logic [CNT_W-1:0] ACK_DRV  = CNT_W'(8);
  localparam logic [CNT_W-1:0] ACK_END  = CNT_W'(9);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    WR_BYTE,
    RD_BYTE,
    RD_ACK,
    IGNORE
  } state_e;

  state_e           state_q;
  logic [1:0]       scl_sync_q;
  logic [1:0]       sda_sync_q;
  logic             scl_dly_q;
  logic             sda_dly_q;
  logic [7:0]       shift_q;
  logic [CNT_W-1:0] cnt_q;
  logic             rw_q;
  logic [PTR_W-1:0] ptr_q;
  logic [7:0]       mem_q [NUM_REGS];
  logic             sda_oe_q;
  logic             busy_q;
  logic             wr_stb_q;
  logic [PTR_W-1:0] wr_idx_q;

  logic             scl_s_c;
  logic             sda_s_c;
  logic             scl_rise_c;
  logic             scl_fall_c;
  logic             start_c;
  logic             stop_c;
  logic [7:0]       rx_byte_d;
  logic [PTR_W-1:0] ptr_inc_d;
  logic             ptr_ok_c;
  logic [7:0]       cur_byte_c;
  logic [7:0]       nxt_byte_c;

  // Edge and bus-condition detection on the synchronised pad signals.
  assign scl_s_c    = scl_sync_q[1];
  assign sda_s_c    = sda_sync_q[1];
  assign scl_rise_c = scl_s_c & ~scl_dly_q;
  assign scl_fall_c = ~scl_s_c & scl_dly_q;
  assign start_c    = scl_s_c & scl_dly_q & sda_dly_q & ~sda_s_c;
  assign stop_c     = scl_s_c & scl_dly_q & ~sda_dly_q & sda_s_c;

  assign rx_byte_d  = {shift_q[6:0], sda_s_c};
  assign ptr_inc_d  = (ptr_q == PTR_W'(NUM_REGS - 1)) ? '0 : ptr_q + PTR_W'(1);
  assign ptr_ok_c   = 32'(rx_byte_d) < NUM_REGS;
  assign cur_byte_c = mem_q[ptr_q];
  assign nxt_byte_c = mem_q[ptr_inc_d];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_dly_q  <= 1'b1;
      sda_dly_q  <= 1'b1;
      shift_q    <= '0;
      cnt_q      <= '0;
      rw_q       <= 1'b0;
      ptr_q      <= '0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_stb_q   <= 1'b0;
      wr_idx_q   <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= RST_VAL;
      end
    end else begin
      scl_sync_q <= {scl_sync_q[0], bus.scl_in};
      sda_sync_q <= {sda_sync_q[0], bus.sda_in};
      scl_dly_q  <= scl_s_c;
      sda_dly_q  <= sda_s_c;
      wr_stb_q   <= 1'b0;

      if (start_c) begin
        state_q  <= ADDR;
        cnt_q    <= '0;
        sda_oe_q <= 1'b0;
      end else if (stop_c) begin
        state_q  <= IDLE;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: ;

          ADDR: begin
            if (scl_rise_c) begin
              shift_q <= rx_byte_d;
              cnt_q   <= cnt_q + CNT_W'(1);
              if (cnt_q == BIT_LAST) begin
                if (rx_byte_d[7:1] == DEV_ADDR) begin
                  busy_q  <= 1'b1;
                  rw_q    <= rx_byte_d[0];
                  state_q <= ADDR_ACK;
                end else begin
                  busy_q  <= 1'b0;
                  state_q <= IGNORE;
                end
              end
            end
          end

          ADDR_ACK: begin
            if (scl_rise_c && cnt_q == ACK_DRV) begin
              cnt_q <= ACK_END;
            end
            if (scl_fall_c) begin
              if (cnt_q == ACK_DRV) begin
                sda_oe_q <= 1'b1;
              end else if (cnt_q == ACK_END) begin
                if (rw_q) begin
                  // First read bit goes out on the same fall that ends the ACK slot.
                  sda_oe_q <= ~cur_byte_c[7];
                  shift_q  <= {cur_byte_c[6:0], 1'b0};
                  cnt_q    <= CNT_W'(1);
                  state_q  <= RD_BYTE;
                end else begin
                  sda_oe_q <= 1'b0;
                  cnt_q    <= '0;
                  state_q  <= PTR;
                end
              end
            end
          end

          PTR: begin
            if (scl_rise_c && cnt_q < ACK_DRV) begin
              shift_q <= rx_byte_d;
              cnt_q   <= cnt_q + CNT_W'(1);
              if (cnt_q == BIT_LAST) begin
                if (ptr_ok_c) begin
                  ptr_q   <= PTR_W'(rx_byte_d);
                  state_q <= WR_BYTE;
                end else begin
                  busy_q  <= 1'b0;
                  state_q <= IGNORE;
                end
              end
            end
          end

          WR_BYTE: begin
            if (scl_rise_c) begin
              if (cnt_q < ACK_DRV) begin
                shift_q <= rx_byte_d;
                cnt_q   <= cnt_q + CNT_W'(1);
                if (cnt_q == BIT_LAST) begin
                  mem_q[ptr_q] <= rx_byte_d;
                  wr_stb_q     <= 1'b1;
                  wr_idx_q     <= ptr_q;
                  ptr_q        <= ptr_inc_d;
                end
              end else if (cnt_q == ACK_DRV) begin
                cnt_q <= ACK_END;
              end
            end
            if (scl_fall_c) begin
              if (cnt_q == ACK_DRV) begin
                sda_oe_q <= 1'b1;
              end else if (cnt_q == ACK_END) begin
                sda_oe_q <= 1'b0;
                cnt_q    <= '0;
              end
            end
          end

          RD_BYTE: begin
            if (scl_fall_c) begin
              if (cnt_q < ACK_DRV) begin
                sda_oe_q <= ~shift_q[7];
                shift_q  <= {shift_q[6:0], 1'b0};
                cnt_q    <= cnt_q + CNT_W'(1);
              end else begin
                sda_oe_q <= 1'b0;
                state_q  <= RD_ACK;
              end
            end
          end

          RD_ACK: begin
            if (scl_rise_c) begin
              ptr_q <= ptr_inc_d;
              if (!sda_s_c) begin
                shift_q <= nxt_byte_c;
                cnt_q   <= '0;
                state_q <= RD_BYTE;
              end else begin
                busy_q  <= 1'b0;
                state_q <= IGNORE;
              end
            end
          end

          IGNORE: begin
            sda_oe_q <= 1'b0;
            busy_q   <= 1'b0;
          end

          default: state_q <= IDLE;
        endcase
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
    assign regs_q[8*g +: 8] = mem_q[g];
  end

  assign bus.sda_oe = sda_oe_q;
  assign wr_stb     = wr_stb_q;
  assign wr_idx     = wr_idx_q;
  assign busy       = busy_q;

endmodule
